// File: rtl/nes_timing_pkg.sv
// Shared timing definitions for the NES master-clock tick generator:
// FSM state encoding, NTSC divider constants and a counter-width helper.
package nes_timing_pkg;

  localparam int PPU_DIV_NTSC = 4;
  localparam int CPU_DIV_NTSC = 12;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PAUSING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_STEP    = 2'd3
  } tick_state_e;

  // Width of a counter spanning 0..div-1; never narrower than one bit.
  function automatic int ph_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/nes_tick_gen_if.sv
// Control and tick-output bundle of the tick generator. The generator
// uses the master view; a consumer of the ticks uses the slave view.
interface nes_tick_gen_if;

  logic        pause_req;
  logic        step;
  logic        ppu_ce;
  logic        cpu_ce;
  logic        apu_ce;
  logic        m2;
  logic        paused;
  logic        step_done;
  logic [15:0] cpu_cycles;

  modport master (
    input  pause_req, step,
    output ppu_ce, cpu_ce, apu_ce, m2, paused, step_done, cpu_cycles
  );

  modport slave (
    output pause_req, step,
    input  ppu_ce, cpu_ce, apu_ce, m2, paused, step_done, cpu_cycles
  );

endinterface

// File: rtl/nes_phase_ctr.sv
// Wrapping phase counter over one CPU cycle (0..CPU_DIV-1) with an advance
// enable, plus the terminal/phase flags the tick registers are built from.
module nes_phase_ctr
  import nes_timing_pkg::*;
#(
  parameter int CPU_DIV = CPU_DIV_NTSC,
  parameter int PPU_DIV = PPU_DIV_NTSC
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output logic cpu_term,
  output logic ppu_term,
  output logic m2_next
);

  localparam int PW = ph_width(CPU_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(CPU_DIV - 1);

  logic [PW-1:0] ph_q;
  logic [PW-1:0] ph_d;

  always_comb begin
    ph_d = ph_q;
    if (adv) begin
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q <= '0;
    end else begin
      ph_q <= ph_d;
    end
  end

  assign cpu_term = (ph_q == PH_LAST);
  assign ppu_term = ((int'(ph_q) % PPU_DIV) == (PPU_DIV - 1));
  // M2 is high for the second half of the CPU cycle, looking one phase ahead
  // because the output register lands a clock later.
  assign m2_next  = (((int'(ph_q) + 1) % CPU_DIV) >= (CPU_DIV / 2));

endmodule

// File: rtl/nes_tick_gen.sv
// NES clock-enable generator: PPU/CPU/APU enables and M2 from one master
// clock, with pause at CPU-cycle boundaries and single-CPU-cycle stepping.
module nes_tick_gen
  import nes_timing_pkg::*;
#(
  parameter int PPU_DIV = PPU_DIV_NTSC,
  parameter int CPU_DIV = CPU_DIV_NTSC
) (
  input  logic                  clk,
  input  logic                  rst,
  nes_tick_gen_if.master        bus
);

  tick_state_e state_q;
  tick_state_e state_d;

  logic adv;
  logic cpu_term;
  logic ppu_term;
  logic m2_next;

  logic        ppu_ce_q, ppu_ce_d;
  logic        cpu_ce_q, cpu_ce_d;
  logic        apu_ce_q, apu_ce_d;
  logic        m2_q, m2_d;
  logic        paused_q, paused_d;
  logic        step_done_q, step_done_d;
  logic        toggle_q, toggle_d;
  logic [15:0] cpu_cycles_q, cpu_cycles_d;

  assign adv = (state_q != ST_PAUSED);

  nes_phase_ctr #(
    .CPU_DIV (CPU_DIV),
    .PPU_DIV (PPU_DIV)
  ) u_phase (
    .clk      (clk),
    .rst      (rst),
    .adv      (adv),
    .cpu_term (cpu_term),
    .ppu_term (ppu_term),
    .m2_next  (m2_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.pause_req) begin
          state_d = cpu_term ? ST_PAUSED : ST_PAUSING;
        end
      end
      ST_PAUSING: begin
        if (!bus.pause_req) begin
          state_d = ST_RUN;
        end else if (cpu_term) begin
          state_d = ST_PAUSED;
        end
      end
      // Releasing the pause wins over a simultaneous step request.
      ST_PAUSED: begin
        if (!bus.pause_req) begin
          state_d = ST_RUN;
        end else if (bus.step) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (cpu_term) begin
          state_d = bus.pause_req ? ST_PAUSED : ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Output registers describe the cycle just executed, so paused trails the
  // boundary cpu_ce by one clock.
  always_comb begin
    ppu_ce_d     = adv && ppu_term;
    cpu_ce_d     = adv && cpu_term;
    apu_ce_d     = cpu_ce_d && toggle_q;
    m2_d         = adv && m2_next;
    paused_d     = (state_q == ST_PAUSED);
    step_done_d  = (state_q == ST_STEP) && cpu_term;
    toggle_d     = toggle_q ^ cpu_ce_d;
    cpu_cycles_d = cpu_cycles_q + 16'(cpu_ce_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ppu_ce_q     <= 1'b0;
      cpu_ce_q     <= 1'b0;
      apu_ce_q     <= 1'b0;
      m2_q         <= 1'b0;
      paused_q     <= 1'b0;
      step_done_q  <= 1'b0;
      toggle_q     <= 1'b0;
      cpu_cycles_q <= 16'd0;
    end else begin
      ppu_ce_q     <= ppu_ce_d;
      cpu_ce_q     <= cpu_ce_d;
      apu_ce_q     <= apu_ce_d;
      m2_q         <= m2_d;
      paused_q     <= paused_d;
      step_done_q  <= step_done_d;
      toggle_q     <= toggle_d;
      cpu_cycles_q <= cpu_cycles_d;
    end
  end

  assign bus.ppu_ce     = ppu_ce_q;
  assign bus.cpu_ce     = cpu_ce_q;
  assign bus.apu_ce     = apu_ce_q;
  assign bus.m2         = m2_q;
  assign bus.paused     = paused_q;
  assign bus.step_done  = step_done_q;
  assign bus.cpu_cycles = cpu_cycles_q;

endmodule

// File: doc/nes_tick_gen.md
NES_TICK_GEN -- requirements
Module: nes_tick_gen

Interface
REQ-001 Parameter PPU_DIV, default 4: master clocks per PPU dot.
REQ-002 Parameter CPU_DIV, default 12: master clocks per CPU cycle; SHALL be an integer multiple of PPU_DIV.
REQ-003 clk  in  1  master clock; the only clock. All logic SHALL be on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 pause_req  in  1  level; request to halt at the next CPU-cycle boundary.
REQ-006 step  in  1  one-clk pulse; run exactly one CPU cycle while paused.
REQ-007 ppu_ce  out  1  one-clk PPU dot enable.
REQ-008 cpu_ce  out  1  one-clk CPU cycle enable.
REQ-009 apu_ce  out  1  one-clk enable on every second cpu_ce.
REQ-010 m2  out  1  CPU phase-2 level.
REQ-011 paused  out  1  high while halted.
REQ-012 step_done  out  1  one-clk pulse when a step completes.
REQ-013 cpu_cycles  out  16  count of cpu_ce pulses; wraps modulo 2^16.

Function
REQ-014 Phase counter ph (0..CPU_DIV-1) SHALL increment on each clk while the state is RUN, PAUSING or STEP, and wrap to 0 after CPU_DIV-1.
REQ-015 All outputs SHALL be registered. On an advancing edge: ppu_ce <= (ph mod PPU_DIV == PPU_DIV-1); cpu_ce <= (ph == CPU_DIV-1); m2 <= (ph+1 mod CPU_DIV >= CPU_DIV/2).
REQ-016 ppu_ce, cpu_ce and apu_ce SHALL be low on any edge where ph does not advance.
REQ-017 The first ppu_ce SHALL occur after the PPU_DIV-th edge following reset release. The first cpu_ce SHALL occur after the CPU_DIV-th edge, and SHALL coincide with the (CPU_DIV/PPU_DIV)-th ppu_ce.
REQ-018 An apu toggle SHALL flip on every cpu_ce. apu_ce SHALL equal cpu_ce AND toggle==1 (before flip), so the first cpu_ce after reset has no apu_ce and the second has apu_ce.
REQ-019 cpu_cycles SHALL increment in the same edge cpu_ce is set. 0xFFFF wraps to 0x0000.
REQ-020 FSM states: RUN, PAUSING, PAUSED, STEP.
REQ-021 RUN with pause_req=1: if ph==CPU_DIV-1, go to PAUSED; otherwise go to PAUSING.
REQ-022 PAUSING: keep advancing. At ph==CPU_DIV-1, go to PAUSED after emitting that cycle's cpu_ce. If pause_req drops first, return to RUN with no gap in ticks.
REQ-023 PAUSED: ph held at 0, paused=1, m2 held low.
REQ-024 PAUSED with pause_req=0: go to RUN on the next edge. A step in that same cycle SHALL be ignored.
REQ-025 PAUSED with step=1 and pause_req=1: go to STEP. STEP SHALL advance exactly CPU_DIV clocks, producing CPU_DIV/PPU_DIV ppu_ce and exactly one cpu_ce.
REQ-026 STEP completion: pulse step_done together with cpu_ce. Go to PAUSED if pause_req=1, otherwise RUN.
REQ-027 step pulses received outside PAUSED, including during STEP, SHALL be ignored (no queuing).
REQ-028 paused SHALL be 1 only in PAUSED. It SHALL rise on the edge after the boundary cpu_ce.

Reset
REQ-029 On rst assertion, asynchronously and regardless of state: state=RUN, ph=0, toggle=0, cpu_cycles=0, and all 1-bit outputs = 0.
REQ-030 Reset during STEP or PAUSING SHALL abandon the operation. step_done SHALL not be pulsed.
REQ-031 Ticks SHALL resume per REQ-017 after release.

Structure
REQ-032 A shared package nes_timing_pkg SHALL hold the FSM state enum and the NTSC constants PPU_DIV_NTSC=4 and CPU_DIV_NTSC=12.
REQ-033 A single sub-module, nes_phase_ctr, is natural: the wrapping phase counter with advance enable and terminal flags. The FSM and output registers stay in the top.

Verification
REQ-034 Release reset and free-run 48 clks -> 12 ppu_ce, 4 cpu_ce at edges 12/24/36/48, apu_ce at 24 and 48, cpu_cycles=4.
REQ-035 Raise pause_req at ph=5 -> ticks continue to the boundary cpu_ce. paused=1 on the next edge. No ce for 100 clks. cpu_cycles frozen.
REQ-036 While paused, pulse step -> exactly 3 ppu_ce, 1 cpu_ce, step_done together with cpu_ce, then paused=1 again. A second step sent mid-step is ignored.
REQ-037 Preload cpu_cycles near 0xFFFF by running 65535 cpu cycles, then one more cpu_ce -> 0x0000.
REQ-038 Assert rst in the middle of STEP -> all outputs 0 at once, no step_done. After release, the first cpu_ce comes 12 clks later.
REQ-039 Deassert pause_req during PAUSING -> no missing ppu_ce; spacing stays exactly 4 clks.
